// File: rtl/gcd_pkg.sv
// Shared FSM state type and parameter defaults for the GCD request arbiter.
// Optional feature macro: GCD_ARB_TIMEOUT_EN (adds the FLUSH state).
package gcd_pkg;

    localparam int GCD_NREQ_DEF        = 4;
    localparam int GCD_W_DEF           = 16;
    localparam int GCD_TIMEOUT_CYC_DEF = 1023;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_DELIVER = 3'd3
`ifdef GCD_ARB_TIMEOUT_EN
        , S_FLUSH = 3'd4
`endif
    } gcd_state_e;

    // Wrap base+off into 0..n-1; both inputs are already below n.
    function automatic int rr_index(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/gcd_rr_arb.sv
// Combinational round-robin pick: first requester at or after the pointer wins.
// Optional feature macro: none (used unchanged by GCD_ARB_TIMEOUT_EN builds).
module gcd_rr_arb
    import gcd_pkg::*;
#(
    parameter int NREQ = GCD_NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!o_any && i_req[rr_index(int'(i_ptr), off, NREQ)]) begin
                o_any = 1'b1;
                o_grant[rr_index(int'(i_ptr), off, NREQ)] = 1'b1;
                o_idx = IW'(rr_index(int'(i_ptr), off, NREQ));
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD core between NREQ clients: grant, launch, wait, deliver.
// Optional feature macro: GCD_ARB_TIMEOUT_EN (WAIT watchdog plus FLUSH state).
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int NREQ        = GCD_NREQ_DEF,
    parameter int W           = GCD_W_DEF,
    parameter int TIMEOUT_CYC = GCD_TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   res_valid,
    input  logic [NREQ-1:0]   res_ready,
    output logic [W-1:0]      res_data,
    output logic              res_err,
    output logic              core_start,
    output logic              core_res_fetch,
    output logic [W-1:0]      core_a,
    output logic [W-1:0]      core_b,
    input  logic              core_res_rdy,
    input  logic [W-1:0]      core_res
);

    localparam int IW = $clog2(NREQ);

    gcd_state_e      r_state, w_next;
    logic [IW-1:0]   r_ptr, r_owner;
    logic [W-1:0]    r_core_a, r_core_b, r_res_data;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic            w_grant_any;
    logic            w_capture;
    logic            w_owner_rdy;
    logic            w_err;

    gcd_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    assign w_capture   = (r_state == S_IDLE) && w_grant_any;
    assign w_owner_rdy = res_ready[r_owner];

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_wait_cnt;
    logic          r_err;
    logic          w_timeout;
    assign w_timeout = (r_wait_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_err     = r_err;
`else
    assign w_err     = 1'b0;
`endif

    assign res_err  = w_err;
    assign res_data = r_res_data;
    assign core_a   = r_core_a;
    assign core_b   = r_core_b;

    always_comb begin
        w_next         = r_state;
        ack            = '0;
        res_valid      = '0;
        core_start     = 1'b0;
        core_res_fetch = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    ack    = w_grant;
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (core_res_rdy)   w_next = S_DELIVER;
`ifdef GCD_ARB_TIMEOUT_EN
                else if (w_timeout) w_next = S_DELIVER;
`endif
            end
            S_DELIVER: begin
                res_valid[r_owner] = 1'b1;
                // A timed-out result has nothing in the core to fetch yet.
                core_res_fetch = w_owner_rdy && !w_err;
                if (w_owner_rdy) begin
`ifdef GCD_ARB_TIMEOUT_EN
                    w_next = r_err ? S_FLUSH : S_IDLE;
`else
                    w_next = S_IDLE;
`endif
                end
            end
`ifdef GCD_ARB_TIMEOUT_EN
            S_FLUSH: begin
                core_res_fetch = core_res_rdy;
                if (core_res_rdy) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge; all state uses non-blocking updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_core_a   <= '0;
            r_core_b   <= '0;
            r_res_data <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_owner  <= w_grant_idx;
                r_ptr    <= (w_grant_idx == IW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
                r_core_a <= a_in[w_grant_idx*W +: W];
                r_core_b <= b_in[w_grant_idx*W +: W];
            end
            if (r_state == S_WAIT && core_res_rdy) r_res_data <= core_res;
`ifdef GCD_ARB_TIMEOUT_EN
            if (r_state == S_LAUNCH)    r_wait_cnt <= '0;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_state == S_WAIT && !core_res_rdy && w_timeout) begin
                r_err      <= 1'b1;
                r_res_data <= '0;
            end
            if (r_state == S_DELIVER && w_owner_rdy) r_err <= 1'b0;
`endif
        end
    end

endmodule
